approx_prod_div_16x8: RTL and testbench

- Sequential radix-2 restoring divider: 16-bit dividend by 8-bit divisor, producing a 16-bit quotient and an 8-bit remainder.
- This is the inverse-direction companion to the 8x8 approximate multiplier library. The error-characterization harness uses it to recover an operand from an (approximate) 16-bit product: R / B gives the effective A.
- Valid/ready handshake on both input and output; one quotient bit is resolved per clock.

---
 rtl/approx_prod_div_16x8.sv | 128 ++++++++++++
 tb/tb_approx_prod_div_16x8.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/approx_prod_div_16x8.sv
// Sequential radix-2 restoring divider, one quotient bit per clock.
// Recovers an operand from an approximate product: quotient = R / B.
module approx_prod_div_16x8 #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [DW-1:0] q;
  logic [VW-1:0] rem;
  logic [VW-1:0] dvs;
  logic [CW-1:0] cnt;
  logic          dbz;
  logic          ov;
  logic          rdy;
  logic          acc;
  logic          fire;
  logic [VW:0]   sh;
  logic [VW:0]   diff;
  logic          neg;

  // Trial subtraction on the shifted partial remainder. rem < dvs
  // holds before each step, so sh - dvs fits VW+1 signed bits.
  always_comb begin
    sh   = {rem, q[DW-1]};
    diff = sh - {1'b0, dvs};
    neg  = diff[VW];
  end

  // Handshake qualifiers.
  always_comb begin
    acc  = (state == IDLE) && in_valid;
    fire = ov && out_ready;
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (acc) begin
          nxt = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          nxt = DONE;
        end
      end
      DONE: begin
        if (fire) begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Datapath, counter and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
      dbz <= 1'b0;
      ov  <= 1'b0;
      rdy <= 1'b1;
    end else begin
      rdy <= (nxt == IDLE);
      ov  <= (state == DONE) && !fire;
      unique case (state)
        IDLE: begin
          if (acc) begin
            dvs <= divisor;
            rem <= '0;
            cnt <= CW'(DW - 1);
            dbz <= (divisor == '0);
            q   <= (divisor == '0) ? '1 : dividend;
          end
        end
        CALC: begin
          q   <= {q[DW-2:0], ~neg};
          rem <= neg ? sh[VW-1:0] : diff[VW-1:0];
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = rdy;
  assign out_valid   = ov;
  assign quotient    = q;
  assign remainder   = rem;
  assign div_by_zero = dbz;

endmodule

// File: tb/tb_approx_prod_div_16x8.sv
// Bench for approx_prod_div_16x8: directed cases plus random
// sweep against integer divide, with latency and stall checks.
module tb_approx_prod_div_16x8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  approx_prod_div_16x8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] a,
                        input logic [7:0]  b,
                        input int          hold,
                        input bit          pulse,
                        input bit          noise);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    int          lat;
    int          n;
    logic [31:0] recon;
    ez  = (b == 8'd0);
    eq  = ez ? 16'hFFFF : a / b;
    er  = ez ? 8'd0 : 8'(a % b);
    lat = ez ? 1 : 17;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      if (noise) out_ready = 1'($urandom);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("latency", 32'(n), 32'(lat));
    chk("quotient", 32'(quotient), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
    chk("div_by_zero", 32'(div_by_zero), 32'(ez));
    if (!ez) begin
      recon = 32'(quotient) * 32'(b) + 32'(remainder);
      chk("identity", recon, 32'(a));
      chk("rem_lt_div", 32'(remainder < b), 32'd1);
    end
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        in_valid = 1'($urandom);
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_q", 32'(quotient), 32'(eq));
      chk("stall_r", 32'(remainder), 32'(er));
      chk("stall_dbz", 32'(div_by_zero), 32'(ez));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    run_op(16'd1000, 8'd7, 0, 1'b0, 1'b0);
    run_op(16'd65535, 8'd255, 0, 1'b0, 1'b0);
    run_op(16'd50000, 8'd200, 0, 1'b0, 1'b0);
    run_op(16'd100, 8'd200, 0, 1'b0, 1'b0);
    run_op(16'd0, 8'd5, 0, 1'b0, 1'b0);
    run_op(16'd54321, 8'd1, 0, 1'b0, 1'b0);
    run_op(16'd1234, 8'd0, 0, 1'b0, 1'b0);
    run_op(16'd9, 8'd3, 0, 1'b0, 1'b0);
    run_op(16'd777, 8'd13, 10, 1'b1, 1'b0);
    run_op(16'd4321, 8'd0, 3, 1'b1, 1'b0);

    @(negedge clk);
    dividend = 16'd40000;
    divisor  = 8'd3;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_q", 32'(quotient), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'd40000, 8'd3, 0, 1'b0, 1'b0);

    for (int k = 0; k < 2000; k++) begin
      logic [15:0] ra;
      logic [7:0]  rb;
      ra = 16'($urandom);
      rb = 8'($urandom_range(1, 255));
      if (k % 7 == 0) rb = 8'($urandom_range(1, 3));
      run_op(ra, rb, $urandom_range(0, 2), 1'b1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
